// File: rtl/coffee_pkg.sv
// coffee_pkg: dispenser states, change-bit positions and coin codes shared with the vending FSM
package coffee_pkg;
  typedef enum logic [2:0] {IDLE, EJECT10, WAIT10, EJECT5, WAIT5, FAULT} state_t;
  localparam int CHG_5C = 0;
  localparam int CHG_10C = 1;
  localparam logic [1:0] I_5C = 2'b01;
  localparam logic [1:0] I_10C = 2'b10;
  localparam logic [1:0] I_20C = 2'b11;
endpackage

// File: rtl/coffee_change_dispenser_if.sv
// coffee_change_dispenser_if: vend/sensor/refill inputs and ejector/status outputs of the change dispenser
interface coffee_change_dispenser_if;
  logic coffee;
  logic [1:0] change;
  logic coin_sensed;
  logic refill;
  logic refill_sel;
  logic eject_5c;
  logic eject_10c;
  logic busy;
  logic done;
  logic fault;
  logic overrun;
  logic exact_change;
  logic [3:0] count_5c;
  logic [3:0] count_10c;
  modport master (
    output coffee, change, coin_sensed, refill, refill_sel,
    input eject_5c, eject_10c, busy, done, fault, overrun, exact_change, count_5c, count_10c
  );
  modport slave (
    input coffee, change, coin_sensed, refill, refill_sel,
    output eject_5c, eject_10c, busy, done, fault, overrun, exact_change, count_5c, count_10c
  );
endinterface

// File: rtl/coin_tube_counter.sv
// coin_tube_counter: saturating coin-tube inventory (inc/dec in, count/empty out)
module coin_tube_counter #(
  parameter int TUBE_DEPTH = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       empty
);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !dec && count < 4'(TUBE_DEPTH)) count <= count + 1'b1;
    else if (dec && !inc && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/coffee_change_dispenser.sv
// coffee_change_dispenser: pays change 10c-then-5c via timed ejector pulses confirmed by coin_sensed; bus carries vend/sensor/refill in, ejectors/status/counts out
module coffee_change_dispenser
  import coffee_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TUBE_DEPTH = 15
) (
  input logic clk,
  input logic reset,
  coffee_change_dispenser_if.slave bus
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic coffee_q, seen, seen_n, chg5, chg5_n, vend, dec5, dec10, done_n, e5, e10;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  assign vend = bus.coffee & ~coffee_q;
  coin_tube_counter #(.TUBE_DEPTH(TUBE_DEPTH)) u_tube_5c (
    .clk(clk), .reset(reset), .inc(bus.refill & ~bus.refill_sel), .dec(dec5),
    .count(bus.count_5c), .empty(e5)
  );
  coin_tube_counter #(.TUBE_DEPTH(TUBE_DEPTH)) u_tube_10c (
    .clk(clk), .reset(reset), .inc(bus.refill & bus.refill_sel), .dec(dec10),
    .count(bus.count_10c), .empty(e10)
  );
  always_comb begin
    state_n = state;
    chg5_n = chg5;
    seen_n = seen;
    pcnt_n = pcnt;
    tcnt_n = tcnt;
    done_n = 1'b0;
    dec10 = bus.coin_sensed & ~seen & (state == EJECT10 || state == WAIT10);
    dec5 = bus.coin_sensed & ~seen & (state == EJECT5 || state == WAIT5);
    case (state)
      IDLE: if (vend) begin
        chg5_n = bus.change[CHG_5C];
        seen_n = 1'b0;
        pcnt_n = '0;
        if (bus.change == 2'b00) done_n = 1'b1;
        else if ((bus.change[CHG_10C] && e10) || (bus.change[CHG_5C] && e5)) state_n = FAULT;
        else state_n = bus.change[CHG_10C] ? EJECT10 : EJECT5;
      end
      EJECT10, EJECT5: begin
        // a coin dropping mid-pulse is remembered and acted on in the first wait cycle
        seen_n = seen | bus.coin_sensed;
        pcnt_n = pcnt + 1'b1;
        tcnt_n = '0;
        if (pcnt == PW'(PULSE_CYCLES - 1)) state_n = (state == EJECT10) ? WAIT10 : WAIT5;
      end
      WAIT10, WAIT5: begin
        tcnt_n = tcnt + 1'b1;
        if (seen || bus.coin_sensed) begin
          done_n = !(state == WAIT10 && chg5);
          state_n = done_n ? IDLE : EJECT5;
          seen_n = 1'b0;
          pcnt_n = '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) state_n = FAULT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      coffee_q <= 1'b0;
      chg5 <= 1'b0;
      seen <= 1'b0;
      pcnt <= '0;
      tcnt <= '0;
      bus.eject_10c <= 1'b0;
      bus.eject_5c <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.fault <= 1'b0;
      bus.overrun <= 1'b0;
      bus.exact_change <= 1'b0;
    end else begin
      state <= state_n;
      coffee_q <= bus.coffee;
      chg5 <= chg5_n;
      seen <= seen_n;
      pcnt <= pcnt_n;
      tcnt <= tcnt_n;
      bus.eject_10c <= state_n == EJECT10;
      bus.eject_5c <= state_n == EJECT5;
      bus.busy <= state_n inside {EJECT10, WAIT10, EJECT5, WAIT5};
      bus.done <= done_n;
      bus.fault <= state_n == FAULT;
      bus.overrun <= bus.overrun | (vend & (state != IDLE));
      bus.exact_change <= e5 | e10;
    end
endmodule

// File: tb/tb_coffee_change_dispenser.sv
// tb_coffee_change_dispenser: directed and randomized dispenses checked against a timeline model
module tb_coffee_change_dispenser;
  localparam int P = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m5 = 0;
  int m10 = 0;
  bit m_fault = 0;
  bit m_over = 0;
  coffee_change_dispenser_if bus();
  coffee_change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(TO), .TUBE_DEPTH(15)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int e10, input int e5, input int b, input int d, input int f, input int o);
    chk({tag, " eject_10c"}, 8'(bus.eject_10c), 8'(e10));
    chk({tag, " eject_5c"}, 8'(bus.eject_5c), 8'(e5));
    chk({tag, " busy"}, 8'(bus.busy), 8'(b));
    chk({tag, " done"}, 8'(bus.done), 8'(d));
    chk({tag, " fault"}, 8'(bus.fault), 8'(f));
    chk({tag, " overrun"}, 8'(bus.overrun), 8'(o));
  endtask
  task automatic chk_idle(input string tag);
    chk_out(tag, 0, 0, 0, 0, int'(m_fault), int'(m_over));
    chk({tag, " count_5c"}, 8'(bus.count_5c), 8'(m5));
    chk({tag, " count_10c"}, 8'(bus.count_10c), 8'(m10));
    chk({tag, " exact_change"}, 8'(bus.exact_change), 8'(m5 == 0 || m10 == 0));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.coffee = 1'b0;
    bus.coin_sensed = 1'b0;
    bus.refill = 1'b0;
    tick();
    tick();
    m5 = 0;
    m10 = 0;
    m_fault = 0;
    m_over = 0;
    chk_out("in_reset", 0, 0, 0, 0, 0, 0);
    chk("in_reset exact_change", 8'(bus.exact_change), 8'd0);
    reset = 1'b0;
    tick();
    chk_idle("after_reset");
  endtask
  task automatic refill(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      bus.refill = 1'b1;
      bus.refill_sel = sel;
      tick();
      if (sel) m10 = (m10 < 15) ? m10 + 1 : 15;
      else m5 = (m5 < 15) ? m5 + 1 : 15;
    end
    bus.refill = 1'b0;
    tick();
  endtask
  // r10/r5: cycle of the coin's pulse (0 = first eject cycle) at which the sensor fires, -1 = never
  // re: cycle after the vend edge at which a second vend edge is made, -1 = none
  task automatic dispense(input logic [1:0] chg, input int r10, input int r5, input int re_in);
    bit e10a[64] = '{default: 0};
    bit e5a[64] = '{default: 0};
    bit ba[64] = '{default: 0};
    bit da[64] = '{default: 0};
    bit sa[64] = '{default: 0};
    int cur = 1;
    int stop = -1;
    int re = re_in;
    int last;
    bit over;
    if (chg == 2'b00) da[1] = 1;
    else if ((chg[1] && m10 == 0) || (chg[0] && m5 == 0)) stop = 1;
    else begin
      for (int k = 0; k < 2; k++) begin
        bit is10 = (k == 0);
        int r = is10 ? r10 : r5;
        if ((is10 ? chg[1] : chg[0]) && stop < 0) begin
          for (int i = 0; i < P; i++) if (is10) e10a[cur + i] = 1; else e5a[cur + i] = 1;
          if (r < 0) begin
            for (int i = 0; i < P + TO; i++) ba[cur + i] = 1;
            stop = cur + P + TO;
          end else begin
            int n = cur + ((r > P) ? r : P) + 1;
            sa[cur + r] = 1;
            for (int i = cur; i < n; i++) ba[i] = 1;
            if (is10) m10--; else m5--;
            cur = n;
          end
        end
      end
      if (stop < 0) da[cur] = 1;
    end
    last = ((stop >= 0) ? stop : cur) + 2;
    if (re < 2 || re >= last || !(ba[re] || (stop >= 0 && re >= stop))) re = -1;
    over = re > 0;
    bus.coffee = 1'b1;
    bus.change = chg;
    tick();
    for (int c = 1; c <= last; c++) begin
      bus.change = 2'($urandom);
      bus.coin_sensed = sa[c];
      bus.coffee = !(re > 0 && c == re - 1);
      chk_out("dispense", e10a[c], e5a[c], ba[c], da[c], int'(stop >= 0 && c >= stop), int'(m_over || (over && c > re)));
      tick();
    end
    bus.coffee = 1'b0;
    bus.coin_sensed = 1'b0;
    if (stop >= 0) m_fault = 1;
    if (over) m_over = 1;
    tick();
    chk_idle("after_dispense");
  endtask
  task automatic vend_in_fault;
    bus.coffee = 1'b1;
    tick();
    m_over = 1;
    chk_out("vend_in_fault", 0, 0, 0, 0, 1, 1);
    bus.coffee = 1'b0;
    tick();
  endtask
  initial begin
    bus.coffee = 1'b0;
    bus.change = 2'b00;
    bus.coin_sensed = 1'b0;
    bus.refill = 1'b0;
    bus.refill_sel = 1'b0;
    do_reset();
    refill(0, 3);
    refill(1, 2);
    chk_idle("refilled");
    dispense(2'b11, P + 1, P + 1, -1);
    dispense(2'b00, -1, -1, -1);
    do_reset();
    refill(1, 1);
    dispense(2'b01, 0, 0, -1);
    refill(0, 2);
    chk_idle("fault_sticky");
    do_reset();
    refill(1, 3);
    dispense(2'b10, -1, -1, -1);
    do_reset();
    refill(0, 16);
    refill(1, 2);
    chk_idle("saturated");
    dispense(2'b11, P + 2, 1, P + 1);
    dispense(2'b10, P + TO - 1, 0, -1);
    for (int it = 0; it < 25; it++) begin
      if (m_fault) begin
        if ($urandom_range(1, 0) == 1) vend_in_fault();
        do_reset();
      end
      refill(0, int'($urandom_range(2, 0)));
      refill(1, int'($urandom_range(2, 0)));
      dispense(2'($urandom),
               ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(P + TO - 1, 0)),
               ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(P + TO - 1, 0)),
               ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 2)) : -1);
    end
    do_reset();
    refill(0, 1);
    refill(1, 1);
    bus.coffee = 1'b1;
    bus.change = 2'b11;
    tick();
    for (int c = 1; c < P + 2; c++) begin
      bus.coin_sensed = (c == P + 1);
      tick();
    end
    bus.coin_sensed = 1'b0;
    chk("mid_eject5 eject_5c", 8'(bus.eject_5c), 8'd1);
    chk("mid_eject5 count_10c", 8'(bus.count_10c), 8'd0);
    reset = 1'b1;
    tick();
    m5 = 0;
    m10 = 0;
    m_fault = 0;
    m_over = 0;
    chk_out("reset_mid", 0, 0, 0, 0, 0, 0);
    chk("reset_mid count_5c", 8'(bus.count_5c), 8'd0);
    chk("reset_mid exact_change", 8'(bus.exact_change), 8'd0);
    reset = 1'b0;
    bus.coffee = 1'b0;
    tick();
    chk_idle("reset_mid_release");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/coffee_change_dispenser.md
Name: coffee_change_dispenser

Overview:
Return-path companion to the coffee vending FSM: takes the vend strobe (`coffee`) and change code that FSM produces and physically pays out change. It drives the 10c and 5c coin ejector solenoids, one coin at a time, and confirms each coin on the chute drop sensor. It also tracks coin-tube inventory and reports jams, empty tubes and overruns to the front panel.

Parameters:
PULSE_CYCLES, 4, width of each ejector solenoid pulse in clk cycles (>=1)
TIMEOUT_CYCLES, 255, cycles allowed after pulse end for coin_sensed before jam fault (>=1)
TUBE_DEPTH, 15, max coins per tube; counts saturate here (<=15)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
coffee  input  1  vend level from vending FSM; a 0->1 transition is a vend event
change  input  2  change code sampled on the vend event: bit0 = one 5c coin, bit1 = one 10c coin
coin_sensed  input  1  chute drop sensor, one-cycle pulse per coin (pre-synchronised)
refill  input  1  one-cycle pulse: one coin loaded into the tube selected by refill_sel
refill_sel  input  1  0 = 5c tube, 1 = 10c tube
eject_5c  output  1  5c solenoid drive
eject_10c  output  1  10c solenoid drive
busy  output  1  dispense in progress
done  output  1  one-cycle pulse when a dispense completes successfully
fault  output  1  sticky: jam or insufficient inventory
overrun  output  1  sticky: vend event arrived while busy
exact_change  output  1  high while either tube count is 0
count_5c  output  4  5c tube inventory
count_10c  output  4  10c tube inventory

Behaviour:
- All outputs are registered. Reset values: all outputs 0, counts 0, state IDLE. exact_change is 1 in the first cycle after reset.
- Vend detect: coffee_q holds coffee from the previous cycle. Edge T is the edge where coffee=1 and coffee_q=0. The change input is latched at T.
- States: IDLE, EJECT10, WAIT10, EJECT5, WAIT5, FAULT. The 10c coin is always paid before the 5c coin.
- At T in IDLE:
  - change=00: done=1 in cycle T+1; no eject.
  - Any requested tube has count 0: go to FAULT; no coin ejected, counts unchanged.
  - Otherwise: go to EJECT10 if bit1 is set, else EJECT5.
- EJECTx: eject_x=1 for exactly PULSE_CYCLES cycles, starting at T+1; then WAITx.
- WAITx: timeout counter starts at 0 when the pulse ends.
  - coin_sensed seen in EJECTx or WAITx: that tube decrements by 1. From WAIT10, go to EJECT5 if bit0 is set, else IDLE with done. From WAIT5, go to IDLE with done.
  - A coin_sensed during the pulse advances on the first WAIT cycle.
  - No coin_sensed within TIMEOUT_CYCLES: go to FAULT; no decrement.
- FAULT: eject outputs 0, busy 0, fault=1. FAULT and the fault flag are left only via reset.
- busy=1 in EJECT*/WAIT* states only. done is never asserted in the same cycle as busy.
- A vend event while busy or in FAULT is ignored and sets overrun (sticky until reset).
- coin_sensed in IDLE or FAULT is ignored.
- Refill is accepted in every state; the count saturates at TUBE_DEPTH. A refill and a decrement on the same tube in the same cycle leave the count unchanged.
- reset mid-operation: eject outputs drop on the next edge; all state cleared.
- Counter widths: timeout counter ceil(log2(TIMEOUT_CYCLES+1)) bits; pulse counter ceil(log2(PULSE_CYCLES+1)) bits.

Decomposition:
- Package coffee_pkg holds:
  - state enum;
  - change-bit positions CHG_5C=0, CHG_10C=1;
  - coin codes I_5C/I_10C/I_20C, shared with the vending FSM.
- Sub-module coin_tube_counter (inc, dec, count, empty; saturating, TUBE_DEPTH parameter), instantiated once per tube.

Test Plan:
(bench uses PULSE_CYCLES=4, TIMEOUT_CYCLES=8)
- Reset, refill 5c x3 and 10c x2, coffee 0->1 with change=11, coin_sensed 2 cycles after each pulse -> eject_10c high T+1..T+4, then eject_5c pulse, then done; counts 5c=2, 10c=1; fault=0.
- change=00 vend -> done at T+1, no eject, busy never high.
- change=01 with count_5c=0 -> FAULT at T+1, no eject, fault=1, exact_change=1; later refill increments count but fault stays 1 until reset.
- change=10, no coin_sensed -> eject_10c for 4 cycles, then fault after 8 wait cycles; count_10c unchanged.
- Second coffee edge during WAIT10 -> overrun=1, dispense completes normally; refill 15 coins plus one extra -> count holds at 15.
- reset asserted during EJECT5 -> eject_5c=0 and all outputs at reset values on the next edge.
